cpu7_ifu_fcl: RTL and testbench

CPU7_IFU_FCL -- requirements
Module: cpu7_ifu_fcl

---
 rtl/cpu7_ifu_fcl.sv | 136 +++++++++++++
 tb/tb_cpu7_ifu_fcl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/cpu7_ifu_fcl.sv
// Instruction-fetch control: sequences fetch requests to the I-cache, cancels
// stale fetches on redirects and selects the next pc_bf source for the datapath.
module cpu7_ifu_fcl #(
    parameter int GRLEN = 32
) (
    input  logic             clock,
    input  logic             resetn,
    output logic             inst_req,
    input  logic             inst_addr_ok,
    input  logic             inst_valid,
    output logic             inst_cancel,
    input  logic             br_taken,
    input  logic [GRLEN-1:0] br_target,
    input  logic             exu_ifu_stall_req,
    output logic [3:0]       fcl_fdp_pcbf_sel_l,
    output logic [GRLEN-1:0] fcl_fdp_brtgt,
    output logic             fcl_fdp_dec_valid,
    output logic [1:0]       fcl_state
);

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DROP = 2'b11
    } state_t;

    localparam logic [3:0] SEL_INIT = 4'b1110;
    localparam logic [3:0] SEL_OLD  = 4'b1101;
    localparam logic [3:0] SEL_INC  = 4'b1011;
    localparam logic [3:0] SEL_BR   = 4'b0111;

    state_t           state_r;
    state_t           next_state_s;
    logic [GRLEN-1:0] brtgt_r;
    logic             req_s;

    // State register and held redirect target
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_INIT;
            brtgt_r <= '0;
        end else begin
            state_r <= next_state_s;
            if (br_taken) begin
                brtgt_r <= br_target;
            end else begin
                brtgt_r <= brtgt_r;
            end
        end
    end

    // Next-state and same-cycle control outputs; priority br > stall > valid > addr_ok
    always_comb begin
        next_state_s       = state_r;
        req_s              = 1'b0;
        inst_cancel        = 1'b0;
        fcl_fdp_dec_valid  = 1'b0;
        fcl_fdp_pcbf_sel_l = SEL_OLD;
        case (state_r)
            ST_INIT: begin
                fcl_fdp_pcbf_sel_l = SEL_INIT;
                next_state_s       = ST_REQ;
            end
            ST_REQ: begin
                req_s = ~exu_ifu_stall_req;
                if (br_taken) begin
                    fcl_fdp_pcbf_sel_l = SEL_BR;
                    // an already-accepted request now fetches the wrong path
                    if (inst_addr_ok && req_s) begin
                        inst_cancel  = 1'b1;
                        next_state_s = ST_DROP;
                    end else begin
                        next_state_s = ST_REQ;
                    end
                end else if (exu_ifu_stall_req) begin
                    next_state_s = ST_REQ;
                end else if (inst_addr_ok) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (br_taken) begin
                    if (inst_valid) begin
                        fcl_fdp_pcbf_sel_l = SEL_BR;
                        next_state_s       = ST_REQ;
                    end else begin
                        inst_cancel  = 1'b1;
                        next_state_s = ST_DROP;
                    end
                end else if (exu_ifu_stall_req) begin
                    if (inst_valid) begin
                        next_state_s = ST_REQ;
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end else if (inst_valid) begin
                    fcl_fdp_dec_valid  = 1'b1;
                    fcl_fdp_pcbf_sel_l = SEL_INC;
                    next_state_s       = ST_REQ;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (br_taken) begin
                    next_state_s = ST_DROP;
                end else if (inst_valid) begin
                    fcl_fdp_pcbf_sel_l = SEL_BR;
                    next_state_s       = ST_REQ;
                end else begin
                    next_state_s = ST_DROP;
                end
            end
            default: begin
                fcl_fdp_pcbf_sel_l = SEL_INIT;
                next_state_s       = ST_INIT;
            end
        endcase
    end

    // Redirect target bypasses the holding register in the cycle it arrives
    always_comb begin
        if (br_taken) begin
            fcl_fdp_brtgt = br_target;
        end else begin
            fcl_fdp_brtgt = brtgt_r;
        end
    end

    assign inst_req  = req_s;
    assign fcl_state = state_r;

endmodule

// File: tb/tb_cpu7_ifu_fcl.sv
// Directed scoreboard bench for cpu7_ifu_fcl: each step drives inputs, queues
// the expected outputs, and compares them mid-cycle.
module tb_cpu7_ifu_fcl;

    localparam int GRLEN = 32;

    localparam logic [1:0] S_INIT = 2'b00;
    localparam logic [1:0] S_REQ  = 2'b01;
    localparam logic [1:0] S_WAIT = 2'b10;
    localparam logic [1:0] S_DROP = 2'b11;

    localparam logic [3:0] SI = 4'b1110;
    localparam logic [3:0] SO = 4'b1101;
    localparam logic [3:0] SN = 4'b1011;
    localparam logic [3:0] SB = 4'b0111;

    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic             inst_addr_ok = 1'b0;
    logic             inst_valid = 1'b0;
    logic             br_taken = 1'b0;
    logic             exu_ifu_stall_req = 1'b0;
    logic [GRLEN-1:0] br_target = '0;
    logic             inst_req;
    logic             inst_cancel;
    logic [3:0]       fcl_fdp_pcbf_sel_l;
    logic [GRLEN-1:0] fcl_fdp_brtgt;
    logic             fcl_fdp_dec_valid;
    logic [1:0]       fcl_state;

    typedef struct packed {
        logic [1:0]  st;
        logic        req;
        logic        cancel;
        logic        dec;
        logic [3:0]  sel;
        logic [31:0] tgt;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    cpu7_ifu_fcl #(.GRLEN(GRLEN)) dut (
        .clock              (clock),
        .resetn             (resetn),
        .inst_req           (inst_req),
        .inst_addr_ok       (inst_addr_ok),
        .inst_valid         (inst_valid),
        .inst_cancel        (inst_cancel),
        .br_taken           (br_taken),
        .br_target          (br_target),
        .exu_ifu_stall_req  (exu_ifu_stall_req),
        .fcl_fdp_pcbf_sel_l (fcl_fdp_pcbf_sel_l),
        .fcl_fdp_brtgt      (fcl_fdp_brtgt),
        .fcl_fdp_dec_valid  (fcl_fdp_dec_valid),
        .fcl_state          (fcl_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic compare(input int idx);
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("state[%0d]", idx), {30'd0, fcl_state}, {30'd0, e.st});
        chk($sformatf("inst_req[%0d]", idx), {31'd0, inst_req}, {31'd0, e.req});
        chk($sformatf("inst_cancel[%0d]", idx), {31'd0, inst_cancel}, {31'd0, e.cancel});
        chk($sformatf("dec_valid[%0d]", idx), {31'd0, fcl_fdp_dec_valid}, {31'd0, e.dec});
        chk($sformatf("pcbf_sel_l[%0d]", idx), {28'd0, fcl_fdp_pcbf_sel_l}, {28'd0, e.sel});
        chk($sformatf("brtgt[%0d]", idx), fcl_fdp_brtgt, e.tgt);
        chk($sformatf("sel_onehot[%0d]", idx), $countones(~fcl_fdp_pcbf_sel_l), 32'd1);
    endtask

    int step_no = 0;

    task automatic step(input logic aok, input logic vld, input logic br, input logic stl,
                        input logic [31:0] tgt, input logic [1:0] st, input logic req,
                        input logic cancel, input logic dec, input logic [3:0] sel,
                        input logic [31:0] etgt);
        exp_t e;
        inst_addr_ok      = aok;
        inst_valid        = vld;
        br_taken          = br;
        exu_ifu_stall_req = stl;
        br_target         = tgt;
        e = '{st: st, req: req, cancel: cancel, dec: dec, sel: sel, tgt: etgt};
        exp_q.push_back(e);
        @(negedge clock);
        compare(step_no);
        step_no++;
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        // held in reset
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, S_INIT, 1'b0, 1'b0, 1'b0, SI, 32'h0);
        resetn = 1'b1;
        // straight-line fetch
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, S_INIT, 1'b0, 1'b0, 1'b0, SI, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, S_REQ,  1'b1, 1'b0, 1'b0, SO, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, S_WAIT, 1'b0, 1'b0, 1'b1, SN, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, S_REQ,  1'b1, 1'b0, 1'b0, SO, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, S_WAIT, 1'b0, 1'b0, 1'b1, SN, 32'h0);
        // branch in WAIT without valid, then the stale return
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, S_REQ,  1'b1, 1'b0, 1'b0, SO, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h1C000100, S_WAIT, 1'b0, 1'b1, 1'b0, SO, 32'h1C000100);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, S_DROP, 1'b0, 1'b0, 1'b0, SO, 32'h1C000100);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, S_DROP, 1'b0, 1'b0, 1'b0, SB, 32'h1C000100);
        // branch coincident with addr_ok in REQ
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h20000040, S_REQ, 1'b1, 1'b1, 1'b0, SB, 32'h20000040);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, S_DROP, 1'b0, 1'b0, 1'b0, SB, 32'h20000040);
        // branch in REQ without addr_ok stays in REQ
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h30000000, S_REQ, 1'b1, 1'b0, 1'b0, SB, 32'h30000000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, S_REQ,  1'b1, 1'b0, 1'b0, SO, 32'h30000000);
        // stall with valid in WAIT, then stall holds off the request
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, S_WAIT, 1'b0, 1'b0, 1'b0, SO, 32'h30000000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, S_REQ,  1'b0, 1'b0, 1'b0, SO, 32'h30000000);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, S_REQ,  1'b0, 1'b0, 1'b0, SO, 32'h30000000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, S_REQ,  1'b1, 1'b0, 1'b0, SO, 32'h30000000);
        // branch with valid in WAIT
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h40000000, S_WAIT, 1'b0, 1'b0, 1'b0, SB, 32'h40000000);
        // protocol-error valid in REQ is ignored
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, S_REQ,  1'b1, 1'b0, 1'b0, SO, 32'h40000000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, S_REQ,  1'b1, 1'b0, 1'b0, SO, 32'h40000000);
        // branch in WAIT into DROP, second branch in DROP updates target only
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h50000000, S_WAIT, 1'b0, 1'b1, 1'b0, SO, 32'h50000000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h60000000, S_DROP, 1'b0, 1'b0, 1'b0, SO, 32'h60000000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, S_DROP, 1'b0, 1'b0, 1'b0, SO, 32'h60000000);
        // reset asserted while in DROP
        resetn = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, S_INIT, 1'b0, 1'b0, 1'b0, SI, 32'h0);
        resetn = 1'b1;
        // late valid after release is not decoded
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, S_INIT, 1'b0, 1'b0, 1'b0, SI, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, S_REQ,  1'b1, 1'b0, 1'b0, SO, 32'h0);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
